// File: rtl/vc_plane_scheduler.sv
// vc_plane_scheduler
//   Time-multiplexes the shared switch/allocator datapath between VC planes.
//   Planes are granted round-robin with a cycle quantum. A plane that still
//   holds a busy output or a reserved input port keeps the grant until those
//   clear, so packets already in flight finish on their own plane.
//
//   State | Meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no plane owns the datapath; selector holds its last value
//   ACTIVE| selected plane owns the datapath; quantum counter running
//   DRAIN | quantum over (or requests gone) but plane still holds resources
//
// Ports
//   clk              clock, all state on rising edge
//   rst              asynchronous active-high reset
//   valid_out_portVC per-plane flit valid, plane v = [v*OUTPUTS +: OUTPUTS]
//   outputBusyVC     per-plane output busy, same packing
//   PortReservedVC   per-plane input reservation, plane v = [v*INPUTS +: INPUTS]
//   VCPlaneSelector  registered selected plane index (always < VC)
//   plane_active     selected plane owns the datapath (ACTIVE or DRAIN)
//   plane_switch     one-cycle pulse when the selector takes a new value
module vc_plane_scheduler #(
  parameter int VC      = 4,
  parameter int INPUTS  = 4,
  parameter int OUTPUTS = 4,
  parameter int QUANTUM = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VC*OUTPUTS-1:0]   valid_out_portVC,
  input  logic [VC*OUTPUTS-1:0]   outputBusyVC,
  input  logic [VC*INPUTS-1:0]    PortReservedVC,
  output logic [VC:0]             VCPlaneSelector,
  output logic                    plane_active,
  output logic                    plane_switch
);

  localparam int SelW = (VC > 1) ? $clog2(VC) : 1;
  localparam int CntW = $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } stateT;

  stateT           state, stateNext;
  logic [SelW-1:0] sel, selNext;
  logic [SelW-1:0] ptr, ptrNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            switchNext;

  logic [VC-1:0]   req;
  logic [VC-1:0]   hold;
  logic            anyReq;
  logic            found;
  logic            grant;
  logic [SelW-1:0] arbWinner;

  always_comb begin
    req  = '0;
    hold = '0;
    for (int v = 0; v < VC; v++) begin
      req[v]  = |valid_out_portVC[v*OUTPUTS +: OUTPUTS];
      hold[v] = (|outputBusyVC[v*OUTPUTS +: OUTPUTS]) |
                (|PortReservedVC[v*INPUTS +: INPUTS]);
    end
  end

  // Search starts just after the pointer, so the current plane comes last.
  always_comb begin
    anyReq    = |req;
    found     = 1'b0;
    arbWinner = ptr;
    for (int k = 1; k <= VC; k++) begin
      if (!found && req[(int'(ptr) + k) % VC]) begin
        found     = 1'b1;
        arbWinner = SelW'((int'(ptr) + k) % VC);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      ptr          <= SelW'(VC - 1);
      cnt          <= '0;
      plane_switch <= 1'b0;
    end else begin
      state        <= stateNext;
      sel          <= selNext;
      ptr          <= ptrNext;
      cnt          <= cntNext;
      plane_switch <= switchNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext  = state;
    selNext    = sel;
    ptrNext    = ptr;
    cntNext    = cnt;
    grant      = 1'b0;
    switchNext = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) grant = 1'b1;
      end
      ACTIVE: begin
        if (cnt != '0 && req[sel]) begin
          cntNext = cnt - CntW'(1);
        end else if (hold[sel]) begin
          stateNext = DRAIN;
        end else if (anyReq) begin
          grant = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      DRAIN: begin
        // No timeout: the plane keeps the datapath until it lets go.
        if (!hold[sel]) begin
          if (anyReq) grant = 1'b1;
          else        stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (grant) begin
      stateNext  = ACTIVE;
      selNext    = arbWinner;
      ptrNext    = arbWinner;
      cntNext    = CntW'(QUANTUM - 1);
      // Re-granting the plane already shown on the selector is not a switch.
      switchNext = (arbWinner != sel);
    end
  end

  // Output logic
  always_comb begin
    VCPlaneSelector             = '0;
    VCPlaneSelector[SelW-1:0]   = sel;
    plane_active                = (state != IDLE);
  end

endmodule
